// File: rtl/line_window_buffer_if.sv
// Pixel stream in / window stream out for line_window_buffer.
// The master drives the raster stream and line size; the slave (the buffer) drives windows.
interface line_window_buffer_if #(
    parameter int N            = 8,
    parameter int K            = 3,
    parameter int ADDRESS_SIZE = 12
);
    logic [ADDRESS_SIZE-1:0] size;
    logic                    in_valid;
    logic [N-1:0]            in_data;
    logic [ADDRESS_SIZE-1:0] in_x;
    logic [ADDRESS_SIZE-1:0] in_y;
    logic                    in_done;

    logic                    out_valid;
    logic [K*K*N-1:0]        out_window;
    logic                    out_full;
    logic [ADDRESS_SIZE-1:0] out_x;
    logic [ADDRESS_SIZE-1:0] out_y;
    logic                    out_done;

    modport master (
        output size, in_valid, in_data, in_x, in_y, in_done,
        input  out_valid, out_window, out_full, out_x, out_y, out_done
    );

    modport slave (
        input  size, in_valid, in_data, in_x, in_y, in_done,
        output out_valid, out_window, out_full, out_x, out_y, out_done
    );
endinterface

// File: rtl/line_window_buffer.sv
// KxK sliding-window generator over a raster pixel stream.
// K-1 line memories hold previous rows; a KxK shift array forms the window.
// Fixed two-cycle latency: stage 1 captures the new column, stage 2 shifts and gates it.
module line_window_buffer #(
    parameter int N            = 8,
    parameter int K            = 3,
    parameter int MAX_WIDTH    = 4096,
    parameter int ADDRESS_SIZE = 12
) (
    input  logic               clock,
    input  logic               reset_n,
    line_window_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t state_q, state_d;
    logic   flush_cnt_q, flush_cnt_d;

    logic                    frame_start;
    logic                    accept;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [ADDRESS_SIZE-1:0] addr_eff;
    logic [ADDRESS_SIZE-1:0] addr_last;
    logic [ADDRESS_SIZE-1:0] size_q;

    logic [N-1:0] line_mem [K-1][MAX_WIDTH];
    logic [N-1:0] line_rd  [K-1];
    logic [N-1:0] wr_data  [K-1];

    logic                    s1_valid;
    logic                    s1_done;
    logic [ADDRESS_SIZE-1:0] s1_x;
    logic [ADDRESS_SIZE-1:0] s1_y;
    logic [N-1:0]            s1_col [K];

    logic [N-1:0]     win_q [K][K];
    logic [N-1:0]     win_d [K][K];
    logic [K*K*N-1:0] win_gated;

    // A (0,0) pixel starts a frame from any state; other pixels only count inside a frame.
    assign frame_start = bus.in_valid && (bus.in_x == '0) && (bus.in_y == '0);
    assign accept      = frame_start || (bus.in_valid && (state_q == ACTIVE));
    assign addr_eff    = frame_start ? '0 : addr_q;
    // A size of 0 wraps to all-ones here, i.e. a full MAX_WIDTH line.
    assign addr_last   = (frame_start ? bus.size : size_q) - ADDRESS_SIZE'(1);

    // Frame state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Frame state transitions: FLUSH lasts two cycles while the pipeline drains.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = bus.in_done ? FLUSH : ACTIVE;
            end
            ACTIVE: begin
                if (bus.in_done) state_d = FLUSH;
            end
            FLUSH: begin
                if (frame_start)      state_d = bus.in_done ? FLUSH : ACTIVE;
                else if (flush_cnt_q) state_d = IDLE;
                else                  flush_cnt_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line address counter and size latch, both restarted by a frame start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            size_q <= '0;
        end else if (accept) begin
            if (frame_start) size_q <= bus.size;
            addr_q <= (addr_eff == addr_last) ? '0 : addr_eff + ADDRESS_SIZE'(1);
        end
    end

    // Line memory read port and cascade data: line j feeds line j+1.
    always_comb begin
        for (int unsigned j = 0; j < K - 1; j++) begin
            line_rd[j] = line_mem[j][addr_eff];
        end
        wr_data[0] = bus.in_data;
        for (int unsigned j = 1; j < K - 1; j++) begin
            wr_data[j] = line_rd[j-1];
        end
    end

    // Line memory write, read-before-write at the same address.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int unsigned j = 0; j < K - 1; j++) begin
                line_mem[j][addr_eff] <= wr_data[j];
            end
        end
    end

    // Stage 1: capture the incoming column (oldest row at index 0) and its coordinates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_done  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_col   <= '{default: '0};
        end else begin
            s1_valid <= accept;
            s1_done  <= bus.in_done;
            if (accept) begin
                s1_x       <= bus.in_x;
                s1_y       <= bus.in_y;
                s1_col[K-1] <= bus.in_data;
                for (int unsigned j = 0; j < K - 1; j++) begin
                    s1_col[K-2-j] <= line_rd[j];
                end
            end
        end
    end

    // Shift the window one column and blank elements that fall outside the image.
    always_comb begin
        win_d     = win_q;
        win_gated = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = s1_col[r];
        end
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                if ((s1_x >= ADDRESS_SIZE'(K-1-c)) && (s1_y >= ADDRESS_SIZE'(K-1-r))) begin
                    win_gated[(r*K+c)*N +: N] = win_d[r][c];
                end
            end
        end
    end

    // Stage 2: window register and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_q          <= '{default: '0};
            bus.out_valid  <= 1'b0;
            bus.out_done   <= 1'b0;
            bus.out_window <= '0;
            bus.out_full   <= 1'b0;
            bus.out_x      <= '0;
            bus.out_y      <= '0;
        end else begin
            bus.out_valid <= s1_valid;
            bus.out_done  <= s1_done;
            if (s1_valid) begin
                win_q          <= win_d;
                bus.out_window <= win_gated;
                bus.out_full   <= (s1_x >= ADDRESS_SIZE'(K-1)) && (s1_y >= ADDRESS_SIZE'(K-1));
                bus.out_x      <= s1_x;
                bus.out_y      <= s1_y;
            end
        end
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer with K=3, N=8.
module tb_line_window_buffer;
    localparam int N  = 8;
    localparam int K  = 3;
    localparam int AS = 12;
    localparam int W  = K * K * N;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    line_window_buffer_if #(.N(N), .K(K), .ADDRESS_SIZE(AS)) bus ();

    line_window_buffer #(.N(N), .K(K), .MAX_WIDTH(4096), .ADDRESS_SIZE(AS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clock) cyc <= cyc + 1;

    int           mon_x[$];
    int           mon_y[$];
    int           mon_cyc[$];
    int           done_cyc[$];
    int           drv_cyc[$];
    logic [W-1:0] mon_win[$];
    logic         mon_full[$];

    // Output collector, sampled on the falling edge.
    always @(negedge clock) begin
        if (bus.out_valid === 1'b1) begin
            mon_x.push_back(int'(bus.out_x));
            mon_y.push_back(int'(bus.out_y));
            mon_win.push_back(bus.out_window);
            mon_full.push_back(bus.out_full);
            mon_cyc.push_back(cyc);
        end
        if (bus.out_done === 1'b1) done_cyc.push_back(cyc);
    end

    function automatic logic [N-1:0] pix(int base, int w, int x, int y);
        return N'(base + y * w + x);
    endfunction

    // Reference window: element (r,c) is pixel (x-(K-1-c), y-(K-1-r)), zero outside the image.
    function automatic logic [W-1:0] exp_win(int base, int w, int x, int y);
        logic [W-1:0] e;
        e = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if ((x - (K-1-c)) >= 0 && (y - (K-1-r)) >= 0)
                    e[(r*K+c)*N +: N] = pix(base, w, x - (K-1-c), y - (K-1-r));
            end
        end
        return e;
    endfunction

    task automatic drive(input logic v, input int x, input int y, input logic [N-1:0] d, input logic done);
        @(negedge clock);
        bus.in_valid = v;
        bus.in_x     = AS'(x);
        bus.in_y     = AS'(y);
        bus.in_data  = d;
        bus.in_done  = done;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5, 5, '0, 1'b0);
    endtask

    task automatic clear_mon();
        mon_x.delete(); mon_y.delete(); mon_win.delete(); mon_full.delete();
        mon_cyc.delete(); done_cyc.delete(); drv_cyc.delete();
    endtask

    // Raster frame; gaps inserts idle cycles on 3 of every 10 pixels; size may change at index chg_at.
    task automatic send_frame(input int base, input int w, input int h, input bit gaps,
                              input int chg_at, input int new_size);
        for (int i = 0; i < w * h; i++) begin
            if (gaps && ((i % 10) == 1 || (i % 10) == 4 || (i % 10) == 7)) idle(1 + (i % 3));
            if (i == chg_at) bus.size = AS'(new_size);
            drive(1'b1, i % w, i / w, pix(base, w, i % w, i / w), (i == w * h - 1));
            drv_cyc.push_back(cyc);
        end
        idle(5);
    endtask

    task automatic test_reset();
        @(negedge clock);
        compared++;
        if (bus.out_valid !== 1'b0 || bus.out_done !== 1'b0 || bus.out_full !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_flags: valid=%b done=%b full=%b required 0 0 0", bus.out_valid, bus.out_done, bus.out_full);
        end
        compared++;
        if (bus.out_window !== '0 || bus.out_x !== '0 || bus.out_y !== '0) begin
            mismatched++;
            $display("FAIL reset_data: window=%h x=%0d y=%0d required all 0", bus.out_window, bus.out_x, bus.out_y);
        end
        idle(1);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_ramp();
        logic [W-1:0] w22;
        logic [W-1:0] w13;
        w22 = 72'h0a_09_08_06_05_04_02_01_00;
        w13 = 72'h0d_0c_00_09_08_00_05_04_00;
        clear_mon();
        bus.size = AS'(4);
        send_frame(0, 4, 4, 1'b0, -1, 0);
        compared++;
        if (mon_x.size() != 16) begin
            mismatched++;
            $display("FAIL ramp_count: got %0d windows, required 16", mon_x.size());
        end
        for (int i = 0; i < 16 && i < mon_x.size(); i++) begin
            compared++;
            if (mon_x[i] != i % 4 || mon_y[i] != i / 4 || mon_win[i] !== exp_win(0, 4, i % 4, i / 4)
                || mon_full[i] !== ((i % 4) >= 2 && (i / 4) >= 2)) begin
                mismatched++;
                $display("FAIL ramp_px%0d: x=%0d y=%0d full=%b win=%h required x=%0d y=%0d win=%h",
                         i, mon_x[i], mon_y[i], mon_full[i], mon_win[i], i % 4, i / 4, exp_win(0, 4, i % 4, i / 4));
            end
            compared++;
            if (mon_cyc[i] != drv_cyc[i] + 2) begin
                mismatched++;
                $display("FAIL ramp_latency%0d: got %0d cycles, required 2", i, mon_cyc[i] - drv_cyc[i]);
            end
        end
        if (mon_x.size() == 16) begin
            compared++;
            if (mon_win[10] !== w22 || mon_full[10] !== 1'b1) begin
                mismatched++;
                $display("FAIL ramp_win22: win=%h full=%b required %h full=1", mon_win[10], mon_full[10], w22);
            end
            compared++;
            if (mon_win[0] !== '0 || mon_full[0] !== 1'b0) begin
                mismatched++;
                $display("FAIL ramp_win00: win=%h full=%b required 0 full=0", mon_win[0], mon_full[0]);
            end
            compared++;
            if (mon_win[13] !== w13) begin
                mismatched++;
                $display("FAIL ramp_win13: win=%h required %h", mon_win[13], w13);
            end
            compared++;
            if (done_cyc.size() != 1 || done_cyc[0] != drv_cyc[15] + 2 || mon_cyc[15] != drv_cyc[15] + 2) begin
                mismatched++;
                $display("FAIL ramp_done: pulses=%0d at %0d last valid at %0d required 1 at %0d",
                         done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, mon_cyc[15], drv_cyc[15] + 2);
            end
        end
    endtask

    task automatic test_gaps();
        clear_mon();
        bus.size = AS'(4);
        send_frame(0, 4, 4, 1'b1, -1, 0);
        compared++;
        if (mon_x.size() != 16) begin
            mismatched++;
            $display("FAIL gaps_count: got %0d windows, required 16", mon_x.size());
        end
        for (int i = 0; i < 16 && i < mon_x.size(); i++) begin
            compared++;
            if (mon_win[i] !== exp_win(0, 4, i % 4, i / 4) || mon_cyc[i] != drv_cyc[i] + 2) begin
                mismatched++;
                $display("FAIL gaps_px%0d: win=%h lat=%0d required win=%h lat=2",
                         i, mon_win[i], mon_cyc[i] - drv_cyc[i], exp_win(0, 4, i % 4, i / 4));
            end
        end
    endtask

    task automatic test_size_change();
        clear_mon();
        bus.size = AS'(4);
        send_frame(0, 4, 4, 1'b0, 5, 6);
        send_frame(128, 6, 3, 1'b0, -1, 0);
        compared++;
        if (mon_x.size() != 34) begin
            mismatched++;
            $display("FAIL size_count: got %0d windows, required 34", mon_x.size());
        end
        for (int i = 0; i < 34 && i < mon_x.size(); i++) begin
            int base, w, k;
            base = (i < 16) ? 0 : 128;
            w    = (i < 16) ? 4 : 6;
            k    = (i < 16) ? i : i - 16;
            compared++;
            if (mon_win[i] !== exp_win(base, w, k % w, k / w) || mon_x[i] != k % w || mon_y[i] != k / w) begin
                mismatched++;
                $display("FAIL size_px%0d: x=%0d y=%0d win=%h required x=%0d y=%0d win=%h",
                         i, mon_x[i], mon_y[i], mon_win[i], k % w, k / w, exp_win(base, w, k % w, k / w));
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        bus.size = AS'(4);
        for (int i = 0; i < 6; i++) drive(1'b1, i % 4, i / 4, pix(0, 4, i % 4, i / 4), 1'b0);
        drive(1'b1, 2, 1, pix(0, 4, 2, 1), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.out_done !== 1'b0 || bus.out_full !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_flags: valid=%b done=%b full=%b required 0 0 0", bus.out_valid, bus.out_done, bus.out_full);
        end
        compared++;
        if (bus.out_window !== '0 || bus.out_x !== '0 || bus.out_y !== '0) begin
            mismatched++;
            $display("FAIL midreset_data: window=%h x=%0d y=%0d required all 0", bus.out_window, bus.out_x, bus.out_y);
        end
        @(negedge clock);
        reset_n = 1'b1;
        clear_mon();
        drive(1'b1, 3, 1, 8'h77, 1'b0);
        drive(1'b1, 0, 2, 8'h78, 1'b0);
        drive(1'b1, 1, 2, 8'h79, 1'b1);
        idle(4);
        compared++;
        if (mon_x.size() != 0 || done_cyc.size() != 1) begin
            mismatched++;
            $display("FAIL midreset_drop: got %0d windows %0d done, required 0 windows 1 done", mon_x.size(), done_cyc.size());
        end
        clear_mon();
        send_frame(64, 4, 1, 1'b0, -1, 0);
        compared++;
        if (mon_x.size() != 4) begin
            mismatched++;
            $display("FAIL midreset_count: got %0d windows, required 4", mon_x.size());
        end
        for (int i = 0; i < 4 && i < mon_x.size(); i++) begin
            compared++;
            if (mon_win[i] !== exp_win(64, 4, i, 0) || mon_full[i] !== 1'b0) begin
                mismatched++;
                $display("FAIL midreset_px%0d: win=%h full=%b required win=%h full=0", i, mon_win[i], mon_full[i], exp_win(64, 4, i, 0));
            end
        end
    endtask

    initial begin
        bus.size     = AS'(4);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_done  = 1'b0;
        test_reset();
        test_ramp();
        test_gaps();
        test_size_change();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
